// File: rtl/char_rx_fifo.sv
// Keyboard character receive FIFO with a small register-mapped bus port.
// Characters arrive on rising edges of strobe; DATA reads pop the FIFO.
module char_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char,
  input  logic        strobe,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic        gnt,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [3:0] A_DATA = 4'h0;
  localparam logic [3:0] A_STAT = 4'h4;
  localparam logic [3:0] A_CTRL = 4'h8;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
  } bus_req_t;

  bus_req_t bq;
  assign bq  = '{req: req, we: we, addr: addr, wdata: wdata};
  assign gnt = req;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          strobe_q;
  logic          ovf;
  logic          irq_en;

  logic empty, full, capture, data_rd, ctrl_wr, pop, push, drop, flush, ovf_clr;
  logic [31:0] rdata_nxt;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign capture = strobe & ~strobe_q;
  assign data_rd = bq.req & ~bq.we & (bq.addr == A_DATA);
  assign ctrl_wr = bq.req &  bq.we & (bq.addr == A_CTRL);
  assign flush   = ctrl_wr & bq.wdata[2];
  assign ovf_clr = ctrl_wr & bq.wdata[1];
  assign pop     = data_rd & ~empty;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push    = capture & (~full | pop);
  assign drop    = capture & full & ~pop;

  logic unused_wdata;
  assign unused_wdata = ^bq.wdata[31:3];

  // Read data reflects state before this cycle's update.
  always_comb begin
    rdata_nxt = '0;
    if (!bq.we) begin
      case (bq.addr)
        A_DATA: if (!empty) rdata_nxt[8:0] = {1'b1, mem[rd_ptr]};
        A_STAT: begin
          rdata_nxt[0]       = ~empty;
          rdata_nxt[1]       = full;
          rdata_nxt[2]       = ovf;
          rdata_nxt[4 +: CW] = count;
        end
        A_CTRL: rdata_nxt[0] = irq_en;
        default: rdata_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr] <= char;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      strobe_q <= 1'b0;
      ovf      <= 1'b0;
      irq_en   <= 1'b0;
      rvalid   <= 1'b0;
      rdata    <= '0;
      irq      <= 1'b0;
    end else begin
      strobe_q <= strobe;
      rvalid   <= bq.req;
      rdata    <= bq.req ? rdata_nxt : '0;
      irq      <= irq_en & ~empty;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end

      // Clear beats a same-cycle overflow; a flushed capture is not an overflow.
      if (ovf_clr)             ovf <= 1'b0;
      else if (drop && !flush) ovf <= 1'b1;

      if (ctrl_wr) irq_en <= bq.wdata[0];
    end
  end

endmodule

// File: tb/tb_char_rx_fifo.sv
// Directed bench for char_rx_fifo: queue-based reference model checked every
// cycle, plus literal expectations for the documented scenarios.
module tb_char_rx_fifo;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  char;
  logic        strobe, req, we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic        gnt, rvalid, irq;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  char_rx_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .char(char), .strobe(strobe),
    .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: a byte queue plus flags, updated at each rising edge.
  logic [7:0]  q[$];
  logic        m_ovf, m_en, m_prev, m_irq, m_rvalid, m_ok;
  logic [31:0] m_rdata;

  initial begin
    m_ok = 1'b0;
    forever begin
      @(posedge clk);
      if (reset) begin
        q.delete();
        m_ovf = 0; m_en = 0; m_prev = 0; m_irq = 0; m_rvalid = 0; m_rdata = 0;
        m_ok = 1'b1;
      end else begin
        automatic int  n      = q.size();
        automatic bit  cap    = strobe && !m_prev;
        automatic bit  ctl    = req && we && addr == 4'h8;
        automatic bit  popped = req && !we && addr == 4'h0 && n > 0;
        m_rvalid = req;
        m_rdata  = 0;
        if (req && !we) begin
          if (addr == 4'h0 && n > 0) m_rdata = 32'h100 | 32'(q[0]);
          else if (addr == 4'h4)
            m_rdata = (32'(n) << 4) | (m_ovf ? 4 : 0) | (n == DEPTH ? 2 : 0) | (n > 0 ? 1 : 0);
          else if (addr == 4'h8) m_rdata = {31'b0, m_en};
        end
        m_irq  = m_en && n > 0;
        m_prev = strobe;
        if (ctl && wdata[2]) q.delete();
        else begin
          if (popped) void'(q.pop_front());
          if (cap) begin
            if (n < DEPTH || popped) q.push_back(char);
            else m_ovf = 1;
          end
        end
        if (ctl) begin
          m_en = wdata[0];
          if (wdata[1]) m_ovf = 0;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (m_ok) begin
      chk("cyc_gnt", {31'b0, gnt}, {31'b0, req});
      chk("cyc_rvalid", {31'b0, rvalid}, {31'b0, m_rvalid});
      chk("cyc_rdata", rdata, m_rdata);
      chk("cyc_irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic acc(input logic w, input logic [3:0] a, input logic [31:0] d,
                     output logic [31:0] r);
    req = 1; we = w; addr = a; wdata = d;
    tick();
    req = 0; we = 0; wdata = 0;
    r = rdata;
    chk("acc_rvalid", {31'b0, rvalid}, 32'd1);
  endtask

  task automatic rd_exp(input string nm, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] r;
    acc(0, a, 0, r);
    chk(nm, r, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r;
    acc(1, a, d, r);
    chk("wr_rdata", r, 0);
  endtask

  task automatic pulse(input logic [7:0] c);
    char = c; strobe = 1;
    tick();
    strobe = 0;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    char = 0; strobe = 0; req = 0; we = 0; addr = 0; wdata = 0; reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_rvalid", {31'b0, rvalid}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_irq", {31'b0, irq}, 0);
    rd_exp("rst_status", 4'h4, 0);
    rd_exp("rst_ctrl", 4'h8, 0);

    pulse(8'h41);
    rd_exp("basic_data", 4'h0, 32'h141);
    rd_exp("basic_status", 4'h4, 0);

    char = 8'h55; strobe = 1;
    repeat (5) tick();
    strobe = 0;
    tick();
    rd_exp("held_status", 4'h4, 32'h11);
    rd_exp("held_data", 4'h0, 32'h155);

    // Empty FIFO: capture and DATA read together return 0, char is kept.
    char = 8'h33; strobe = 1; req = 1; we = 0; addr = 4'h0;
    tick();
    strobe = 0; req = 0;
    chk("empty_cap_rd", rdata, 0);
    tick();
    rd_exp("empty_cap_kept", 4'h0, 32'h133);

    for (int i = 0; i < 17; i++) pulse(8'(8'h60 + i));
    rd_exp("ovf_status", 4'h4, 32'h107);
    for (int i = 0; i < 16; i++) rd_exp("ovf_order", 4'h0, 32'h160 + 32'(i));
    rd_exp("ovf_empty_rd", 4'h0, 0);
    rd_exp("ovf_still_set", 4'h4, 32'h4);
    wr(4'h8, 32'h2);
    rd_exp("ovf_cleared", 4'h4, 0);

    for (int i = 0; i < 16; i++) pulse(8'(8'h80 + i));
    rd_exp("full_status", 4'h4, 32'h103);
    char = 8'hAA; strobe = 1; req = 1; we = 0; addr = 4'h0;
    tick();
    strobe = 0; req = 0;
    chk("full_pop_data", rdata, 32'h180);
    tick();
    rd_exp("full_pop_status", 4'h4, 32'h103);
    for (int i = 1; i < 16; i++) rd_exp("full_pop_order", 4'h0, 32'h180 + 32'(i));
    rd_exp("full_pop_last", 4'h0, 32'h1AA);
    rd_exp("full_pop_drained", 4'h4, 0);

    wr(4'h8, 32'h1);
    rd_exp("ctrl_en", 4'h8, 32'h1);
    char = 8'h44; strobe = 1;
    tick();
    strobe = 0;
    chk("irq_lag", {31'b0, irq}, 0);
    tick();
    chk("irq_set", {31'b0, irq}, 1);
    wr(4'h8, 32'h5);
    chk("irq_hold", {31'b0, irq}, 1);
    tick();
    chk("irq_flush", {31'b0, irq}, 0);
    rd_exp("flush_status", 4'h4, 0);

    pulse(8'h11);
    pulse(8'h12);
    char = 8'h13; strobe = 1; req = 1; we = 1; addr = 4'h8; wdata = 32'h4;
    tick();
    strobe = 0; req = 0; we = 0; wdata = 0;
    tick();
    rd_exp("flush_vs_cap", 4'h4, 0);
    rd_exp("flush_ctrl", 4'h8, 0);

    for (int i = 0; i < 16; i++) pulse(8'(8'hC0 + i));
    char = 8'hEE; strobe = 1; req = 1; we = 1; addr = 4'h8; wdata = 32'h2;
    tick();
    strobe = 0; req = 0; we = 0; wdata = 0;
    tick();
    rd_exp("clr_beats_ovf", 4'h4, 32'h103);
    rd_exp("clr_head", 4'h0, 32'h1C0);
    wr(4'h8, 32'h4);

    rd_exp("resv_rd", 4'hC, 0);
    wr(4'h0, 32'hFF);
    wr(4'h4, 32'hFF);
    rd_exp("ignored_wr", 4'h4, 0);

    wr(4'h8, 32'h1);
    pulse(8'h01);
    pulse(8'h02);
    pulse(8'h03);
    rd_exp("pre_rst_status", 4'h4, 32'h31);
    reset = 1; req = 1; we = 0; addr = 4'h4;
    tick();
    reset = 0; req = 0;
    chk("rst_mid_rvalid", {31'b0, rvalid}, 0);
    chk("rst_mid_irq", {31'b0, irq}, 0);
    tick();
    chk("rst_mid_rvalid2", {31'b0, rvalid}, 0);
    chk("rst_mid_irq2", {31'b0, irq}, 0);
    rd_exp("rst_mid_status", 4'h4, 0);
    rd_exp("rst_mid_ctrl", 4'h8, 0);
    rd_exp("rst_mid_data", 4'h0, 0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/char_rx_fifo.md
CHAR_RX_FIFO -- requirements
Module: char_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of two, range 2..256.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 char  input  8  keyboard character from upstream char source.
REQ-005 strobe  input  1  upstream character-valid; one push per rising edge.
REQ-006 req  input  1  bus access request.
REQ-007 we  input  1  1 = write, 0 = read.
REQ-008 addr  input  4  byte offset: 0x0 DATA, 0x4 STATUS, 0x8 CTRL; others reserved.
REQ-009 wdata  input  32  write data.
REQ-010 gnt  output  1  grant, combinational, equals req.
REQ-011 rvalid  output  1  response valid, exactly one cycle after each granted access, reads and writes.
REQ-012 rdata  output  32  read data, valid when rvalid=1, otherwise 0.
REQ-013 irq  output  1  interrupt, registered.

Function
REQ-014 Capture SHALL occur on strobe=1 with strobe_q=0; strobe_q is strobe delayed one cycle. A held-high strobe pushes once.
REQ-015 On capture with FIFO not full, char SHALL be written at wr_ptr, wr_ptr SHALL increment modulo DEPTH, and count SHALL increment.
REQ-016 On capture with FIFO full and no pop in the same cycle, the character SHALL be dropped and sticky OVF SHALL set.
REQ-017 A granted read of DATA SHALL return {23'b0, valid, data[7:0]} on the next cycle.
REQ-018 On a DATA read with valid=1, the read SHALL pop: rd_ptr increments modulo DEPTH and count decrements.
REQ-019 On a DATA read with the FIFO empty, the read SHALL return 0 and leave pointers and count unchanged.
REQ-020 Same-cycle capture and pop SHALL both take effect with count unchanged, including when the FIFO is full; no overflow is flagged.
REQ-021 On an empty FIFO, a same-cycle capture and DATA read SHALL return 0, and the character SHALL be stored.
REQ-022 STATUS read SHALL return:
- bit0 = not empty
- bit1 = full
- bit2 = OVF
- bits[12:4] = count
- other bits 0
REQ-023 A STATUS read SHALL have no side effects.
REQ-024 CTRL read SHALL return bit0 = IRQ_EN; other bits 0.
REQ-025 A CTRL write SHALL take bit0 into IRQ_EN.
REQ-026 CTRL write with wdata[1]=1 SHALL clear OVF; clear SHALL win over a same-cycle overflow.
REQ-027 CTRL write with wdata[2]=1 SHALL flush: both pointers to 0, count to 0.
REQ-028 Flush SHALL take priority over a same-cycle capture; that capture is lost and OVF is not set.
REQ-029 Writes to DATA, STATUS and reserved offsets SHALL be ignored but still produce rvalid.
REQ-030 Reads of reserved offsets SHALL return 0.
REQ-031 irq SHALL be registered as IRQ_EN AND (count != 0), reflecting state one cycle after a change.
REQ-032 count SHALL be DEPTH-width+1 bits; full = (count == DEPTH); empty = (count == 0).

Reset
REQ-033 While reset=1 the following SHALL be cleared:
- wr_ptr, rd_ptr and count = 0
- OVF = 0
- IRQ_EN = 0
- strobe_q = 0
- rvalid = 0
- rdata = 0
- irq = 0
REQ-034 Reset asserted mid-operation SHALL discard all stored characters and any access in flight; no rvalid SHALL follow an access granted in the reset cycle.
REQ-035 Storage array contents need no reset.

Verification
REQ-036 Basic path: pulse strobe with char 0x41, then read DATA -> rdata 0x00000141; next STATUS read -> 0x00000000.
REQ-037 Edge detect: strobe held high 5 cycles with char 0x55 -> STATUS count=1.
REQ-038 Overflow: 17 captures with DEPTH=16 -> STATUS 0x00000107. Then:
- 16 DATA reads return the first 16 chars in order
- 17th DATA read returns 0
- CTRL write 0x2 clears OVF
REQ-039 Full with simultaneous pop: with the FIFO full, capture and DATA read in the same cycle -> count stays 16, OVF=0, and the new char is read last.
REQ-040 irq and flush: write CTRL 0x1, then one capture -> irq=1 two cycles after the strobe edge; write CTRL 0x5 -> count 0, irq=0 the cycle after.
REQ-041 Reset mid-stream: 3 chars stored, reset pulsed one cycle -> STATUS 0, CTRL 0, irq=0.
